pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
//   Physical-memory responder on the cache's pmem interface: accepts 128-bit line
//   reads/writes (pmem_read/pmem_write/pmem_resp handshake) and serves them from a
//   16-bit-wide synchronous backing SRAM as an 8-word burst after a fixed access
//   latency. Sits below the cache controller, modelling the main-memory side.
// PARAMETERS
//   LATENCY  4  idle access-latency cycles before the burst starts (0 = no wait)
//   ADDR_W  16  byte-address width of pmem_address and mem_addr
// PORTS
//   clk           in   1    clock, all logic on rising edge
//   reset_n       in   1    asynchronous, active-low reset
//   pmem_read     in   1    line read request, held by cache until pmem_resp
//   pmem_write    in   1    line write request, held by cache until pmem_resp
//   pmem_address  in   16   line byte address; bits [3:0] ignored (forced 0)
//   pmem_wdata    in   128  write line; word i = bits [16i+15:16i]
//   pmem_rdata    out  128  read line, valid in the pmem_resp cycle, held after
//   pmem_resp     out  1    one-cycle completion pulse
//   mem_addr      out  16   backing-SRAM word byte address (line base + 2*i)
//   mem_wdata     out  16   backing-SRAM write data
//   mem_we        out  1    backing-SRAM write strobe
//   mem_re        out  1    backing-SRAM read strobe; mem_rdata valid next cycle
//   mem_rdata     in   16   backing-SRAM read data
//   busy          out  1    high in every state except IDLE
//   proto_err     out  1    high while read and write both asserted in IDLE
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, pmem_rdata=0, pmem_resp=0, mem_we=0,
//     mem_re=0, mem_addr=0, mem_wdata=0, busy=0, proto_err=0, counters=0.
//   States: IDLE, WAIT, BURST, DRAIN, RESP, RELEASE.
//   IDLE: exactly one of read/write high -> latch {addr[15:4],4'b0}, op, wdata;
//     go WAIT (LATENCY>0) else BURST. Both high -> proto_err=1, no transaction.
//   WAIT: down-count LATENCY cycles, then BURST.
//   BURST: 8 cycles, word index i=0..7 (3-bit counter); mem_addr=base+2*i.
//     Write: mem_we=1, mem_wdata=word i. Read: mem_re=1; mem_rdata captured one
//     cycle later into line buffer word i-1. After i=7: read->DRAIN, write->RESP.
//   DRAIN (read only): capture word 7; go RESP.
//   RESP: pmem_resp=1 exactly this cycle; pmem_rdata = assembled line (read);
//     pmem_rdata unchanged on writes; go RELEASE.
//   RELEASE: wait until pmem_read=0 and pmem_write=0 sampled same cycle -> IDLE.
//     A request still held after RESP is never re-served as a new transaction.
//   Timing (cycle 0 = IDLE sampling cycle): read resp in cycle LATENCY+10, write
//     resp in cycle LATENCY+9 (LATENCY=4: read 14, write 13).
//   Request dropped or address/wdata changed mid-transaction: ignored; latched
//     values used, transaction completes and resp still pulses.
//   No strobe (mem_we/mem_re) outside BURST; never both high.
//   Reset mid-burst: aborts at once; partial writes stay in SRAM; no resp issued.
// TESTING
//   LATENCY=4, read 0x1238, SRAM words 0x1230..0x123E = 0xA000+i -> mem_re from
//     cycle 5 at 0x1230 step 2; resp in cycle 14; pmem_rdata=0xA007..A000 (MSW..LSW).
//   Write 0x4000, wdata=0x0007_0006_..._0000 -> mem_we cycles 5..12, mem_wdata=i;
//     resp cycle 13; readback of 0x4000 returns same line.
//   Write then read with one idle cycle between (write-back/stall/load) -> both
//     served; read resp LATENCY+10 after its IDLE sample; no duplicate resp.
//   Read held 3 cycles past resp -> single resp pulse, busy high until drop.
//   read=write=1 in IDLE -> proto_err=1, no strobes, busy=0, no resp.
//   reset_n low during burst word 3 -> outputs 0 same cycle; next read works.

Source files
------------

// File: rtl/pmem_line_responder_if.sv
// Cache-side pmem line interface: request/response handshake between the
// cache controller (master) and the memory responder (slave).
interface pmem_line_responder_if #(
   parameter int ADDR_W = 16
) ();
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [127:0]      pmem_wdata;
   logic [127:0]      pmem_rdata;
   logic              pmem_resp;

   modport master (
      output pmem_read,
      output pmem_write,
      output pmem_address,
      output pmem_wdata,
      input  pmem_rdata,
      input  pmem_resp
   );

   modport slave (
      input  pmem_read,
      input  pmem_write,
      input  pmem_address,
      input  pmem_wdata,
      output pmem_rdata,
      output pmem_resp
   );
endinterface

// File: rtl/pmem_line_responder.sv
// Main-memory model below the cache: serves 128-bit line reads/writes from a
// 16-bit synchronous SRAM as an 8-word burst after a fixed access latency.
// Request fields are latched in IDLE, so a request that is dropped or altered
// mid-transaction still completes with the original address/data.
module pmem_line_responder #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   pmem_line_responder_if.slave   pmem,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [15:0]            mem_wdata,
   output logic                   mem_we,
   output logic                   mem_re,
   input  logic [15:0]            mem_rdata,
   output logic                   busy,
   output logic                   proto_err
);

   localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_BURST   = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_RESP    = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   base_r;
   logic                op_write_r;
   logic [127:0]        wdata_r;
   logic [15:0]         line_r [0:7];
   logic [2:0]          word_r;
   logic [WAIT_W-1:0]   wait_r;
   logic [ADDR_W-1:0]   req_base_s;
   logic                one_req_s;

   // Byte address of word idx within the line starting at base.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [2:0] idx);
      return {base[ADDR_W-1:4], idx, 1'b0};
   endfunction

   // Word idx (16 bits) of a 128-bit line.
   function automatic logic [15:0] word_sel(input logic [127:0] line,
                                            input logic [2:0] idx);
      return line[{idx, 4'd0} +: 16];
   endfunction

   assign req_base_s = {pmem.pmem_address[ADDR_W-1:4], 4'b0000};
   assign one_req_s  = pmem.pmem_read ^ pmem.pmem_write;

   // Transaction FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= ST_IDLE;
         base_r          <= '0;
         op_write_r      <= 1'b0;
         wdata_r         <= 128'd0;
         word_r          <= 3'd0;
         wait_r          <= '0;
         for (int i = 0; i < 8; i++) line_r[i] <= 16'd0;
         pmem.pmem_rdata <= 128'd0;
         pmem.pmem_resp  <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= 16'd0;
         mem_we          <= 1'b0;
         mem_re          <= 1'b0;
         busy            <= 1'b0;
         proto_err       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               pmem.pmem_resp <= 1'b0;
               mem_we         <= 1'b0;
               mem_re         <= 1'b0;
               if (one_req_s) begin
                  base_r     <= req_base_s;
                  op_write_r <= pmem.pmem_write;
                  wdata_r    <= pmem.pmem_wdata;
                  busy       <= 1'b1;
                  proto_err  <= 1'b0;
                  if (LATENCY == 0) begin
                     // No access latency: first burst word goes out next cycle.
                     state_r   <= ST_BURST;
                     word_r    <= 3'd0;
                     mem_addr  <= word_addr(req_base_s, 3'd0);
                     mem_wdata <= word_sel(pmem.pmem_wdata, 3'd0);
                     mem_we    <= pmem.pmem_write;
                     mem_re    <= ~pmem.pmem_write;
                  end else begin
                     state_r <= ST_WAIT;
                     wait_r  <= WAIT_LOAD;
                  end
               end else begin
                  busy      <= 1'b0;
                  proto_err <= pmem.pmem_read & pmem.pmem_write;
               end
            end
            ST_WAIT: begin
               if (wait_r == '0) begin
                  state_r   <= ST_BURST;
                  word_r    <= 3'd0;
                  mem_addr  <= word_addr(base_r, 3'd0);
                  mem_wdata <= word_sel(wdata_r, 3'd0);
                  mem_we    <= op_write_r;
                  mem_re    <= ~op_write_r;
               end else begin
                  wait_r <= wait_r - 1'b1;
               end
            end
            ST_BURST: begin
               // SRAM data lags the read strobe by one cycle.
               if (!op_write_r && (word_r != 3'd0)) begin
                  line_r[word_r - 3'd1] <= mem_rdata;
               end else begin
                  line_r[7] <= line_r[7];
               end
               if (word_r == 3'd7) begin
                  mem_we <= 1'b0;
                  mem_re <= 1'b0;
                  if (op_write_r) begin
                     state_r        <= ST_RESP;
                     pmem.pmem_resp <= 1'b1;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end else begin
                  word_r    <= word_r + 3'd1;
                  mem_addr  <= word_addr(base_r, word_r + 3'd1);
                  mem_wdata <= word_sel(wdata_r, word_r + 3'd1);
               end
            end
            ST_DRAIN: begin
               // Last word arrives now; assemble the line straight into the output.
               pmem.pmem_rdata <= {mem_rdata, line_r[6], line_r[5], line_r[4],
                                   line_r[3], line_r[2], line_r[1], line_r[0]};
               pmem.pmem_resp  <= 1'b1;
               state_r         <= ST_RESP;
            end
            ST_RESP: begin
               pmem.pmem_resp <= 1'b0;
               state_r        <= ST_RELEASE;
            end
            ST_RELEASE: begin
               // A still-held request must not be taken as a new transaction.
               if (!pmem.pmem_read && !pmem.pmem_write) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end else begin
                  state_r <= ST_RELEASE;
               end
            end
            default: begin
               state_r        <= ST_IDLE;
               pmem.pmem_resp <= 1'b0;
               mem_we         <= 1'b0;
               mem_re         <= 1'b0;
               busy           <= 1'b0;
               proto_err      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder: an SRAM model behind the DUT,
// scoreboard queues of expected SRAM strobes and expected line responses.
module tb_pmem_line_responder;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re, busy, proto_err;
   int          cyc = 0;

   pmem_line_responder_if #(.ADDR_W(16)) pif ();

   pmem_line_responder #(.LATENCY(LAT), .ADDR_W(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pmem      (pif),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   // Cycle counter; value n between posedge n and posedge n+1.
   always @(posedge clk) cyc <= cyc + 1;

   // Backing SRAM model, one-cycle read latency.
   logic [15:0] sram    [0:32767];
   logic [15:0] ref_mem [0:32767];
   always @(posedge clk) begin
      if (mem_we) sram[mem_addr[15:1]] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr[15:1]];
   end

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
      int          cyc;
   } strobe_t;

   typedef struct {
      logic [127:0] rdata;
      int           cyc;
   } resp_t;

   strobe_t      sq[$];
   resp_t        rq[$];
   strobe_t      s_exp;
   resp_t        r_exp;
   logic [127:0] last_line;
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor: every strobe and every resp must match the head of its queue.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (mem_re || mem_we) begin
            check_val("strobe_excl", {127'd0, mem_re & mem_we}, 128'd0);
            if (sq.size() == 0) begin
               check_val("unexpected_strobe", 128'd1, 128'd0);
            end else begin
               s_exp = sq.pop_front();
               check_val("strobe_addr", {112'd0, mem_addr}, {112'd0, s_exp.addr});
               check_val("strobe_we", {127'd0, mem_we}, {127'd0, s_exp.we});
               check_val("strobe_cyc", 128'(cyc), 128'(s_exp.cyc));
               if (s_exp.we) check_val("strobe_wdata", {112'd0, mem_wdata}, {112'd0, s_exp.wdata});
            end
         end
         if (pif.pmem_resp) begin
            if (rq.size() == 0) begin
               check_val("spurious_resp", 128'd1, 128'd0);
            end else begin
               r_exp = rq.pop_front();
               check_val("resp_rdata", pif.pmem_rdata, r_exp.rdata);
               check_val("resp_cyc", 128'(cyc), 128'(r_exp.cyc));
            end
         end
      end
   end

   // Push expectations for one transaction starting at the current negedge.
   task automatic push_expect(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                              input int nwords);
      logic [15:0]  base;
      logic [127:0] line;
      base = {addr[15:4], 4'h0};
      for (int i = 0; i < nwords; i++) begin
         sq.push_back('{base + 16'(2 * i), wr, wd[16*i +: 16], cyc + LAT + 1 + i});
      end
      if (nwords == 8) begin
         if (wr) begin
            for (int i = 0; i < 8; i++) ref_mem[base[15:1] + 15'(i)] = wd[16*i +: 16];
            line = last_line;
         end else begin
            for (int i = 0; i < 8; i++) line[16*i +: 16] = ref_mem[base[15:1] + 15'(i)];
            last_line = line;
         end
         rq.push_back('{line, cyc + LAT + (wr ? 9 : 10)});
      end
   endtask

   // Wait for idle, issue one request, wait for resp, optionally hold, then drop.
   task automatic issue(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                        input int hold, input bit perturb);
      int k;
      @(negedge clk);
      k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check_val("idle_timeout", 128'd1, 128'd0);
      push_expect(wr, addr, wd, 8);
      pif.pmem_read    = ~wr;
      pif.pmem_write   = wr;
      pif.pmem_address = addr;
      pif.pmem_wdata   = wd;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) check_val("busy_active", {127'd0, busy}, 128'd1);
         if (perturb && k == 3) begin
            pif.pmem_read    = 1'b0;
            pif.pmem_write   = 1'b0;
            pif.pmem_address = 16'hFFF0;
            pif.pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
         end
      end while (!pif.pmem_resp && k < 60);
      if (k >= 60) check_val("resp_timeout", 128'd1, 128'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_val("busy_hold", {127'd0, busy}, 128'd1);
      end
      pif.pmem_read  = 1'b0;
      pif.pmem_write = 1'b0;
      if (hold > 0) begin
         @(negedge clk);
         @(negedge clk);
         check_val("busy_release", {127'd0, busy}, 128'd0);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_rdata"}, pif.pmem_rdata, 128'd0);
      check_val({tag, "_misc"},
                {107'd0, pif.pmem_resp, mem_we, mem_re, busy, proto_err, mem_addr},
                128'd0);
      check_val({tag, "_wdata"}, {112'd0, mem_wdata}, 128'd0);
   endtask

   logic [127:0] wline;
   int           st;

   initial begin
      for (int i = 0; i < 8; i++) begin
         sram[15'h0918 + 15'(i)]    = 16'hA000 + 16'(i);
         ref_mem[15'h0918 + 15'(i)] = 16'hA000 + 16'(i);
      end
      last_line        = 128'd0;
      pif.pmem_read    = 1'b0;
      pif.pmem_write   = 1'b0;
      pif.pmem_address = 16'h0000;
      pif.pmem_wdata   = 128'd0;
      reset_n          = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset_n = 1'b1;

      // Read of line 0x1230 via unaligned address 0x1238.
      issue(1'b0, 16'h1238, 128'd0, 0, 1'b0);

      // Write 0x4000 with word i = i, then read it back.
      for (int i = 0; i < 8; i++) wline[16*i +: 16] = 16'(i);
      issue(1'b1, 16'h4000, wline, 0, 1'b0);
      issue(1'b0, 16'h4000, 128'd0, 0, 1'b0);

      // Write-back then load of the same line with minimal gap.
      issue(1'b1, 16'h5014, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
      issue(1'b0, 16'h501C, 128'd0, 0, 1'b0);

      // Read held 3 cycles past resp.
      issue(1'b0, 16'h1230, 128'd0, 3, 1'b0);

      // Request dropped and changed mid-transaction.
      issue(1'b1, 16'h6020, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
      issue(1'b0, 16'h6020, 128'd0, 0, 1'b1);

      // Both read and write in IDLE: protocol error, no transaction.
      @(negedge clk);
      while (busy) @(negedge clk);
      pif.pmem_read  = 1'b1;
      pif.pmem_write = 1'b1;
      @(negedge clk);
      check_val("proto_err_set", {126'd0, proto_err, busy}, 128'd2);
      repeat (3) @(negedge clk);
      pif.pmem_read  = 1'b0;
      pif.pmem_write = 1'b0;
      @(negedge clk);
      check_val("proto_err_clr", {127'd0, proto_err}, 128'd0);
      repeat (20) @(negedge clk);

      // Reset asserted during burst word 3 of a read.
      st = cyc;
      push_expect(1'b0, 16'h1230, 128'd0, 4);
      pif.pmem_read    = 1'b1;
      pif.pmem_address = 16'h1230;
      while (cyc < st + LAT + 4 && cyc < st + 50) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      check_val("midreset_queue", 128'(sq.size()), 128'd0);
      last_line     = 128'd0;
      pif.pmem_read = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Normal read after the aborted one.
      issue(1'b0, 16'h123E, 128'd0, 0, 1'b0);

      repeat (20) @(negedge clk);
      check_val("final_strobe_queue", 128'(sq.size()), 128'd0);
      check_val("final_resp_queue", 128'(rq.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
